// File: rtl/mips_mem_requester_pkg.sv
// Shared memory-op definitions: op codes, error codes, FSM states and decode helpers.
package mips_mem_pkg;

   typedef enum logic [3:0] {
      OP_LW   = 4'd0,
      OP_LH   = 4'd1,
      OP_LHU  = 4'd2,
      OP_LB   = 4'd3,
      OP_LBU  = 4'd4,
      OP_SW   = 4'd5,
      OP_SH   = 4'd6,
      OP_SB   = 4'd7,
      OP_MCLR = 4'd8
   } mem_op_t;

   typedef enum logic [1:0] {
      ERR_OK       = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_RANGE    = 2'd2,
      ERR_ILLEGAL  = 2'd3
   } mem_err_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_CAPTURE,
      ST_RESP
   } state_t;

   typedef enum logic [1:0] {
      SZ_NONE,
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } mem_size_t;

   function automatic logic is_legal(input logic [3:0] op);
      return op <= 4'd8;
   endfunction

   function automatic logic is_load(input mem_op_t op);
      return op inside {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU};
   endfunction

   function automatic logic is_store(input mem_op_t op);
      return op inside {OP_SW, OP_SH, OP_SB};
   endfunction

   function automatic logic is_unsigned(input mem_op_t op);
      return op inside {OP_LHU, OP_LBU};
   endfunction

   function automatic mem_size_t size(input mem_op_t op);
      case (op)
         OP_LW, OP_SW:          return SZ_WORD;
         OP_LH, OP_LHU, OP_SH:  return SZ_HALF;
         OP_LB, OP_LBU, OP_SB:  return SZ_BYTE;
         default:               return SZ_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mips_mem_requester_if.sv
// Pipeline-side request/response handshake bundle.
interface mips_mem_requester_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_err;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mips_mem_requester_load_ext.sv
// Load data extension: picks the low byte/half of the raw RAM word and sign/zero extends it.
module mips_load_ext
   import mips_mem_pkg::*;
(
   input  mem_op_t     op_i,
   input  logic [31:0] raw_i,
   output logic [31:0] ext_o
);

   // Extension selected by load op; non-load ops pass the raw word through.
   always_comb begin
      ext_o = raw_i;
      case (op_i)
         OP_LB:   ext_o = {{24{raw_i[7]}}, raw_i[7:0]};
         OP_LBU:  ext_o = {24'd0, raw_i[7:0]};
         OP_LH:   ext_o = {{16{raw_i[15]}}, raw_i[15:0]};
         OP_LHU:  ext_o = {16'd0, raw_i[15:0]};
         default: ext_o = raw_i;
      endcase
   end

endmodule

// File: rtl/mips_mem_requester.sv
// MEM-stage requester: one outstanding load/store/clear, drives the data RAM and returns a response.
module mips_mem_requester
   import mips_mem_pkg::*;
#(
   parameter int MEM_AW      = 5,
   parameter bit CHECK_RANGE = 1'b1
) (
   input  logic                 clk,
   input  logic                 CLR,
   mips_mem_requester_if.slave  pif,
   output logic                 busy,
   output logic [31:0]          mem_addr,
   output logic [31:0]          mem_wdata,
   output logic                 mem_we,
   output logic                 mem_byte,
   output logic                 mem_half,
   output logic                 mem_unsigned,
   output logic                 mem_clr,
   input  logic [31:0]          mem_rdata
);

   state_t      state_q, state_d;
   mem_op_t     op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   mem_err_t    err_q, err_d;

   mem_op_t     req_op_c;
   mem_err_t    req_err_c;
   logic [31:0] ext_data;

   mips_load_ext u_load_ext (
      .op_i  (op_q),
      .raw_i (mem_rdata),
      .ext_o (ext_data)
   );

   // Classify the incoming request; misalignment outranks out-of-range, MCLR skips both.
   always_comb begin
      req_op_c  = mem_op_t'(pif.req_op);
      req_err_c = ERR_OK;
      if (!is_legal(pif.req_op)) begin
         req_err_c = ERR_ILLEGAL;
      end else if (req_op_c != OP_MCLR) begin
         if ((size(req_op_c) == SZ_HALF && pif.req_addr[0]) ||
             (size(req_op_c) == SZ_WORD && pif.req_addr[1:0] != 2'b00))
            req_err_c = ERR_MISALIGN;
         else if (CHECK_RANGE && pif.req_addr[31:MEM_AW] != '0)
            req_err_c = ERR_RANGE;
      end
   end

   // Next-state and output decode; RAM controls held through ACCESS and CAPTURE.
   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      rdata_d       = rdata_q;
      err_d         = err_q;
      pif.req_ready = 1'b0;
      pif.rsp_valid = 1'b0;
      pif.rsp_rdata = '0;
      pif.rsp_err   = '0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_we        = 1'b0;
      mem_byte      = 1'b0;
      mem_half      = 1'b0;
      mem_unsigned  = 1'b0;
      mem_clr       = 1'b0;

      if (state_q == ST_ACCESS || state_q == ST_CAPTURE) begin
         mem_addr     = addr_q;
         mem_byte     = (size(op_q) == SZ_BYTE);
         mem_half     = (size(op_q) == SZ_HALF);
         mem_unsigned = is_unsigned(op_q);
      end

      case (state_q)
         ST_IDLE: begin
            pif.req_ready = 1'b1;
            if (pif.req_valid) begin
               op_d    = req_op_c;
               addr_d  = pif.req_addr;
               wdata_d = pif.req_wdata;
               rdata_d = '0;
               err_d   = req_err_c;
               state_d = (req_err_c == ERR_OK) ? ST_ACCESS : ST_RESP;
            end
         end
         ST_ACCESS: begin
            mem_we  = is_store(op_q);
            mem_clr = (op_q == OP_MCLR);
            case (size(op_q))
               SZ_BYTE: mem_wdata = {4{wdata_q[7:0]}};
               SZ_HALF: mem_wdata = {2{wdata_q[15:0]}};
               default: mem_wdata = wdata_q;
            endcase
            state_d = is_load(op_q) ? ST_CAPTURE : ST_RESP;
         end
         ST_CAPTURE: begin
            rdata_d = ext_data;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            pif.rsp_valid = 1'b1;
            pif.rsp_rdata = rdata_q;
            pif.rsp_err   = err_q;
            if (pif.rsp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and request registers, cleared asynchronously.
   always_ff @(posedge clk or posedge CLR) begin
      if (CLR) begin
         state_q <= ST_IDLE;
         op_q    <= OP_LW;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= ERR_OK;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mips_mem_requester.sv
// Randomized bench for mips_mem_requester with a byte-array reference model and a RAM model.
module tb_mips_mem_requester;

   logic        clk = 1'b0;
   logic        CLR;
   logic        busy;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_we, mem_byte, mem_half, mem_unsigned, mem_clr;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mips_mem_requester_if pif ();

   mips_mem_requester #(.MEM_AW(5), .CHECK_RANGE(1'b1)) dut (
      .clk          (clk),
      .CLR          (CLR),
      .pif          (pif),
      .busy         (busy),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_we       (mem_we),
      .mem_byte     (mem_byte),
      .mem_half     (mem_half),
      .mem_unsigned (mem_unsigned),
      .mem_clr      (mem_clr),
      .mem_rdata    (mem_rdata)
   );

   // ---------------- RAM model (32 bytes, little endian, sync read/write) ----------------
   logic [7:0]  ram [32];
   logic [4:0]  ra0, ra1, ra2, ra3;
   logic [31:0] junk;
   assign ra0 = mem_addr[4:0];
   assign ra1 = ra0 + 5'd1;
   assign ra2 = ra0 + 5'd2;
   assign ra3 = ra0 + 5'd3;

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 32; i++) ram[i] <= 8'h00;
      end else if (mem_we) begin
         ram[ra0] <= mem_wdata[7:0];
         if (!mem_byte) ram[ra1] <= mem_wdata[15:8];
         if (!mem_byte && !mem_half) begin
            ram[ra2] <= mem_wdata[23:16];
            ram[ra3] <= mem_wdata[31:24];
         end
      end
      // upper lanes carry junk for sub-word reads: the requester must ignore them
      if (mem_byte)      mem_rdata <= {junk[31:8], ram[ra0]};
      else if (mem_half) mem_rdata <= {junk[31:16], ram[ra1], ram[ra0]};
      else               mem_rdata <= {ram[ra3], ram[ra2], ram[ra1], ram[ra0]};
   end

   // ---------------- bus monitor ----------------
   int we_cnt = 0, clr_cnt = 0, act_cnt = 0, idle_bad = 0;
   logic [31:0] last_wdata = '0;

   always @(negedge clk) begin
      junk = $urandom();
      if (mem_we) begin
         we_cnt++;
         last_wdata = mem_wdata;
      end
      if (mem_clr) clr_cnt++;
      if (mem_we || mem_clr || mem_byte || mem_half || mem_unsigned || mem_addr != 0) act_cnt++;
      if (!CLR && !busy && (mem_we || mem_clr || mem_byte || mem_half || mem_addr != 0 ||
                            pif.rsp_valid || !pif.req_ready)) idle_bad++;
   end

   // ---------------- reference model ----------------
   logic [7:0] ref_mem [32];

   function automatic int size_of(input int op);
      if (op == 0 || op == 5) return 4;
      if (op == 1 || op == 2 || op == 6) return 2;
      return 1;
   endfunction

   function automatic int exp_err_of(input int op, input logic [31:0] addr);
      if (op > 8) return 3;
      if (op == 8) return 0;
      if (addr % size_of(op) != 0) return 1;
      if (addr >= 32) return 2;
      return 0;
   endfunction

   function automatic logic [31:0] ref_load(input int op, input logic [31:0] addr);
      logic [31:0] v;
      int sz, a;
      sz = size_of(op);
      a  = int'(addr);
      v  = 0;
      for (int i = 0; i < sz; i++) v = v + (32'(ref_mem[a + i]) << (8 * i));
      if ((op == 1 || op == 3) && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
      return v;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
      end
   endtask

   // One full transaction: request, latency count, held response, handshake, checks.
   task automatic do_txn(input int op, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
      int          e, exp_lat, lat, guard, stable_bad, sz;
      logic [31:0] exp_rd, exp_wd, rd;
      logic [1:0]  er;
      int          we0, clr0, act0;
      logic        is_ld, is_st;

      e       = exp_err_of(op, addr);
      is_ld   = (op <= 4);
      is_st   = (op >= 5 && op <= 7);
      exp_lat = (e != 0) ? 1 : (is_ld ? 3 : 2);
      exp_rd  = (e == 0 && is_ld) ? ref_load(op, addr) : 32'd0;
      sz      = size_of(op);
      exp_wd  = (sz == 1) ? {4{wdata[7:0]}} : (sz == 2) ? {2{wdata[15:0]}} : wdata;

      we0 = we_cnt; clr0 = clr_cnt; act0 = act_cnt;

      @(negedge clk);
      guard = 0;
      while (!pif.req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check_eq("req_ready_wait", 32'(guard < 20), 32'd1);
      pif.req_valid = 1'b1;
      pif.req_op    = 4'(op);
      pif.req_addr  = addr;
      pif.req_wdata = wdata;
      @(posedge clk);
      #1;
      // garbage requests while busy must be ignored
      pif.req_valid = 1'($urandom_range(0, 1));
      pif.req_op    = 4'($urandom());
      pif.req_addr  = $urandom();
      pif.req_wdata = $urandom();
      lat = 1;
      while (!pif.rsp_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq("latency", 32'(lat), 32'(exp_lat));
      rd = pif.rsp_rdata;
      er = pif.rsp_err;
      stable_bad = 0;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         if (!pif.rsp_valid || pif.rsp_rdata !== rd || pif.rsp_err !== er) stable_bad++;
      end
      check_eq("rsp_stable", 32'(stable_bad), 32'd0);
      @(negedge clk);
      pif.req_valid = 1'b0;
      pif.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      pif.rsp_ready = 1'b0;
      check_eq("handshake", {30'd0, pif.rsp_valid, pif.req_ready}, 32'd1);
      check_eq("rsp_rdata", rd, exp_rd);
      check_eq("rsp_err", 32'(er), 32'(e));
      check_eq("mem_we_cycles", 32'(we_cnt - we0), 32'((e == 0 && is_st) ? 1 : 0));
      check_eq("mem_clr_cycles", 32'(clr_cnt - clr0), 32'((e == 0 && op == 8) ? 1 : 0));
      if (e == 0 && is_st) check_eq("mem_wdata", last_wdata, exp_wd);
      if (e != 0) check_eq("mem_idle_on_err", 32'(act_cnt - act0), 32'd0);

      if (e == 0 && op == 8) begin
         for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
      end else if (e == 0 && is_st) begin
         for (int i = 0; i < sz; i++) ref_mem[int'(addr) + i] = wdata[8 * i +: 8];
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int clr0, op, hold;
      logic [31:0] addr;

      CLR = 1'b1;
      pif.req_valid = 1'b0;
      pif.req_op    = '0;
      pif.req_addr  = '0;
      pif.req_wdata = '0;
      pif.rsp_ready = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;

      #12;
      check_eq("reset_req_ready", 32'(pif.req_ready), 32'd1);
      check_eq("reset_outputs", {pif.rsp_valid, busy, mem_we, mem_clr, mem_byte, mem_half, mem_unsigned},
               32'd0);
      check_eq("reset_rsp", {pif.rsp_rdata[29:0], pif.rsp_err}, 32'd0);
      check_eq("reset_mem_addr", mem_addr, 32'd0);
      check_eq("reset_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      CLR = 1'b0;

      // directed cases
      do_txn(8, 32'h0, 32'h0, 5);             // MCLR, response held 5 cycles
      do_txn(0, 32'h0, 32'h0, 0);             // LW 0 after clear
      do_txn(5, 32'h8, 32'hDEADBEEF, 0);      // SW
      do_txn(0, 32'h8, 32'h0, 2);             // LW
      do_txn(7, 32'h3, 32'h00000080, 0);      // SB
      do_txn(3, 32'h3, 32'h0, 0);             // LB
      do_txn(4, 32'h3, 32'h0, 1);             // LBU
      do_txn(6, 32'h6, 32'h00008001, 0);      // SH
      do_txn(1, 32'h6, 32'h0, 0);             // LH
      do_txn(2, 32'h6, 32'h0, 0);             // LHU
      do_txn(1, 32'h5, 32'h0, 3);             // LH misaligned
      do_txn(6, 32'h5, 32'h1234, 0);          // SH misaligned
      do_txn(5, 32'h2, 32'h1234, 0);          // SW misaligned
      do_txn(0, 32'h40, 32'h0, 0);            // LW out of range
      do_txn(1, 32'h41, 32'h0, 0);            // misaligned outranks range
      do_txn(7, 32'h20, 32'h5A, 0);           // SB out of range
      do_txn(12, 32'h0, 32'h0, 2);            // illegal op
      do_txn(15, 32'h3, 32'h0, 0);            // illegal op
      do_txn(0, 32'h1C, 32'h0, 0);            // LW top word of RAM

      // asynchronous reset during CAPTURE
      clr0 = clr_cnt;
      @(negedge clk);
      pif.req_valid = 1'b1;
      pif.req_op    = 4'd0;
      pif.req_addr  = 32'h8;
      @(posedge clk);
      #1;
      pif.req_valid = 1'b0;
      @(posedge clk);
      #1;
      CLR = 1'b1;
      #1;
      check_eq("clr_capture", {pif.rsp_valid, pif.req_ready, mem_we, mem_clr, busy}, 32'b01000);
      @(negedge clk);
      CLR = 1'b0;
      @(posedge clk);
      #1;
      check_eq("clr_no_rsp", {pif.rsp_valid, pif.req_ready, busy}, 32'b010);
      check_eq("clr_no_wipe", 32'(clr_cnt - clr0), 32'd0);
      do_txn(0, 32'h8, 32'h0, 0);             // RAM content survives requester reset

      // randomized traffic
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0)       op = $urandom_range(9, 15);
         else if ($urandom_range(0, 39) == 0) op = 8;
         else                                 op = $urandom_range(0, 7);
         if ($urandom_range(0, 3) == 0) addr = $urandom();
         else                           addr = 32'($urandom_range(0, 31));
         hold = $urandom_range(0, 3);
         do_txn(op, addr, $urandom(), hold);
      end

      check_eq("idle_bus_quiet", 32'(idle_bad), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
